// File: rtl/a2d_resp_pkg.sv
// Shared types and sizes for the A2D SPI response slave.
package a2d_resp_pkg;
    localparam int FRAME_BITS_DEF = 16;
    localparam int CHNL_W         = 3;
    localparam int DATA_W         = 12;
    localparam int NUM_CHNL       = 1 << CHNL_W;
    localparam int SHFT_W         = 16;

    typedef enum logic [1:0] {
        WAIT_HI,
        IDLE,
        XFER
    } state_t;
endpackage

// File: rtl/spi_edge_synch.sv
// Two-flop synchronizer plus one edge-detect flop for an asynchronous SPI pin.
module spi_edge_synch #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic [2:0] ff;

    // shift the pin through the synchronizer and edge-detect stages
    always_ff @(posedge clk) begin
        if (rst) ff <= {3{RST_VAL}};
        else     ff <= {ff[1:0], din};
    end

    assign sync = ff[1];
    assign rise = ff[1] & ~ff[2];
    assign fall = ~ff[1] & ff[2];
endmodule

// File: rtl/a2d_spi_resp.sv
// SPI slave returning the channel value selected by the previous valid command frame.
module a2d_spi_resp
    import a2d_resp_pkg::*;
#(
    parameter logic [DATA_W-1:0] RESET_VAL  = 12'h000,
    parameter int                FRAME_BITS = FRAME_BITS_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              SCLK,
    input  logic              MOSI,
    output logic              MISO,
    input  logic              wr_en,
    input  logic [CHNL_W-1:0] wr_chnl,
    input  logic [DATA_W-1:0] wr_data,
    output logic              cmd_vld,
    output logic [CHNL_W-1:0] cmd_chnl,
    output logic              frame_err
);
    localparam int               CNT_W    = $clog2(FRAME_BITS + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_BITS);
    localparam logic [CNT_W-1:0] CNT_SAT  = CNT_W'(FRAME_BITS + 1);

    state_t                           state, state_nxt;
    logic                             ss_sync, ss_rise, ss_fall;
    logic                             sclk_sync, sclk_rise, sclk_fall;
    logic [2:0]                       mosi_ff;
    logic [1:0]                       settle;
    logic [CNT_W-1:0]                 bit_cnt;
    logic [SHFT_W-1:0]                tx_shft, rx_shft;
    logic [DATA_W-1:0]                result;
    logic [NUM_CHNL-1:0][DATA_W-1:0]  chan_val;
    logic                             frame_ok, frame_bad;
    logic [CHNL_W-1:0]                rx_chnl;

    spi_edge_synch #(.RST_VAL(1'b1)) u_ss (
        .clk(clk), .rst(rst), .din(SS_n),
        .sync(ss_sync), .rise(ss_rise), .fall(ss_fall)
    );

    spi_edge_synch #(.RST_VAL(1'b1)) u_sclk (
        .clk(clk), .rst(rst), .din(SCLK),
        .sync(sclk_sync), .rise(sclk_rise), .fall(sclk_fall)
    );

    // MOSI only needs its level; the third stage keeps it age-matched with the SCLK edge pulse
    always_ff @(posedge clk) begin
        if (rst) mosi_ff <= 3'b000;
        else     mosi_ff <= {mosi_ff[1:0], MOSI};
    end

    // the SS_n synchronizer resets high, so wait until it reflects the real pin before trusting a high level
    always_ff @(posedge clk) begin
        if (rst)                 settle <= 2'd0;
        else if (settle != 2'd2) settle <= settle + 2'd1;
    end

    assign rx_chnl = rx_shft[SHFT_W-3 -: CHNL_W];

    // state register
    always_ff @(posedge clk) begin
        if (rst) state <= WAIT_HI;
        else     state <= state_nxt;
    end

    // next state and frame-end classification
    always_comb begin
        state_nxt = state;
        frame_ok  = 1'b0;
        frame_bad = 1'b0;
        case (state)
            WAIT_HI: if (settle == 2'd2 && ss_sync) state_nxt = IDLE;
            IDLE:    if (ss_fall) state_nxt = XFER;
            XFER: begin
                if (ss_rise) begin
                    state_nxt = IDLE;
                    if (bit_cnt == CNT_FULL && rx_shft[SHFT_W-1 -: 2] == 2'b00) frame_ok  = 1'b1;
                    else                                                        frame_bad = 1'b1;
                end
            end
            default: state_nxt = WAIT_HI;
        endcase
    end

    // shift registers, bit counter, captured result and status pulses
    always_ff @(posedge clk) begin
        if (rst) begin
            bit_cnt   <= '0;
            tx_shft   <= '0;
            rx_shft   <= '0;
            result    <= RESET_VAL;
            cmd_chnl  <= '0;
            cmd_vld   <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            cmd_vld   <= frame_ok;
            frame_err <= frame_bad;
            // chan_val is read before this clock's write lands, so a coincident write is not seen
            if (frame_ok) begin
                cmd_chnl <= rx_chnl;
                result   <= chan_val[rx_chnl];
            end
            if (state == IDLE && ss_fall) begin
                tx_shft <= {{(SHFT_W-DATA_W){1'b0}}, result};
                bit_cnt <= '0;
            end else if (state == XFER && !ss_rise) begin
                if (sclk_rise) begin
                    rx_shft <= {rx_shft[SHFT_W-2:0], mosi_ff[2]};
                    if (bit_cnt != CNT_SAT) bit_cnt <= bit_cnt + CNT_W'(1);
                end
                // the falling edge before the first rise is front porch: bit 15 is already on MISO
                if (sclk_fall && bit_cnt != '0 && bit_cnt < CNT_FULL)
                    tx_shft <= tx_shft << 1;
            end
        end
    end

    // channel value registers, writable in any state
    always_ff @(posedge clk) begin
        if (rst)        chan_val <= {NUM_CHNL{RESET_VAL}};
        else if (wr_en) chan_val[wr_chnl] <= wr_data;
    end

    assign MISO = (state == XFER) && tx_shft[SHFT_W-1];
endmodule

// File: tb/tb_a2d_spi_resp.sv
// Directed and randomized frames against a transaction-level model of the response slave.
module tb_a2d_spi_resp;
    localparam logic [11:0] RV = 12'h3C1;
    localparam int          HP = 6;

    logic        clk = 1'b0;
    logic        rst, SS_n, SCLK, MOSI, MISO;
    logic        wr_en;
    logic [2:0]  wr_chnl;
    logic [11:0] wr_data;
    logic        cmd_vld, frame_err;
    logic [2:0]  cmd_chnl;

    int tests = 0;
    int fails = 0;
    int n_vld = 0;
    int n_err = 0;

    logic [11:0] m_chan [8];
    logic [11:0] m_res;
    logic [2:0]  m_chnl;

    a2d_spi_resp #(.RESET_VAL(RV), .FRAME_BITS(16)) dut (
        .clk(clk), .rst(rst), .SS_n(SS_n), .SCLK(SCLK), .MOSI(MOSI), .MISO(MISO),
        .wr_en(wr_en), .wr_chnl(wr_chnl), .wr_data(wr_data),
        .cmd_vld(cmd_vld), .cmd_chnl(cmd_chnl), .frame_err(frame_err)
    );

    always #5 clk = ~clk;

    // count cycles on which each status pulse is high
    always @(negedge clk) begin
        if (cmd_vld)   n_vld++;
        if (frame_err) n_err++;
    end

    task automatic wait_clk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mreset();
        for (int i = 0; i < 8; i++) m_chan[i] = RV;
        m_res  = RV;
        m_chnl = 3'd0;
    endtask

    task automatic wr(input logic [2:0] ch, input logic [11:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_chnl = ch; wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        m_chan[ch] = d;
    endtask

    task automatic frame(input logic [15:0] cmd, input int nrise,
                         input bit mid_wr, input logic [2:0] mch, input logic [11:0] md,
                         input bit cap_wr, input logic [2:0] cch, input logic [11:0] cd,
                         output logic [15:0] word);
        word = 16'h0000;
        @(negedge clk);
        SS_n = 1'b0;
        wait_clk(HP);
        for (int i = 0; i < nrise; i++) begin
            SCLK = 1'b0;
            MOSI = (i < 16) ? cmd[15-i] : 1'b0;
            if (mid_wr && i == 4) begin
                wr(mch, md);
                wait_clk(HP - 2);
            end else begin
                wait_clk(HP);
            end
            if (i < 16) word[15-i] = MISO;
            SCLK = 1'b1;
            wait_clk(HP);
        end
        SS_n = 1'b1;
        wait_clk(2);
        if (cap_wr) begin
            wr_en = 1'b1; wr_chnl = cch; wr_data = cd;
        end
        wait_clk(1);
        wr_en = 1'b0;
        wait_clk(4);
    endtask

    task automatic run(input string tag, input logic [15:0] cmd, input int nrise,
                       input bit mid_wr, input logic [2:0] mch, input logic [11:0] md,
                       input bit cap_wr, input logic [2:0] cch, input logic [11:0] cd);
        logic [15:0] w, exp, mask;
        int          v0, e0;
        bit          ok;
        mask = (nrise >= 16) ? 16'hFFFF : ~(16'hFFFF >> nrise);
        exp  = {4'h0, m_res} & mask;
        v0   = n_vld;
        e0   = n_err;
        frame(cmd, nrise, mid_wr, mch, md, cap_wr, cch, cd, w);
        ok = (nrise == 16) && (cmd[15:14] == 2'b00);
        if (ok) begin
            m_res  = m_chan[cmd[13:11]];
            m_chnl = cmd[13:11];
        end
        if (cap_wr) m_chan[cch] = cd;
        chk({tag, " miso"}, 32'(w & mask), 32'(exp));
        chk({tag, " vld"},  32'(n_vld - v0), ok ? 32'd1 : 32'd0);
        chk({tag, " err"},  32'(n_err - e0), ok ? 32'd0 : 32'd1);
        chk({tag, " chnl"}, 32'(cmd_chnl), 32'(m_chnl));
    endtask

    task automatic plain(input string tag, input logic [15:0] cmd, input int nrise);
        run(tag, cmd, nrise, 1'b0, 3'd0, 12'h000, 1'b0, 3'd0, 12'h000);
    endtask

    initial begin
        int          v0, e0, nr;
        logic [15:0] cmd;
        logic [1:0]  top;
        rst = 1'b1; SS_n = 1'b1; SCLK = 1'b1; MOSI = 1'b0;
        wr_en = 1'b0; wr_chnl = 3'd0; wr_data = 12'h000;
        mreset();
        wait_clk(4);
        rst = 1'b0;
        wait_clk(5);
        chk("rst cmd_vld", 32'(cmd_vld), 32'd0);
        chk("rst frame_err", 32'(frame_err), 32'd0);
        chk("rst cmd_chnl", 32'(cmd_chnl), 32'd0);
        chk("rst MISO", 32'(MISO), 32'd0);

        // basic command / response pair
        wr(3'd5, 12'hA5C);
        plain("f1", 16'h2800, 16);
        plain("f2", 16'h0000, 16);

        // short frame, then check the result survived
        plain("short", 16'h1800, 12);
        plain("after_short", 16'h0000, 16);

        // malformed command bits
        plain("f_c000", 16'hC000, 16);

        // write coinciding with capture of the same channel
        wr(3'd3, 12'h777);
        run("cap3", 16'h1800, 16, 1'b0, 3'd0, 12'h000, 1'b1, 3'd3, 12'h123);
        plain("post_cap", 16'h1800, 16);
        plain("ch3_new", 16'h0000, 16);

        // randomized frames, some with writes during the transfer
        for (int k = 0; k < 12; k++) begin
            if ($urandom_range(0, 1) == 1) wr(3'($urandom_range(0, 7)), 12'($urandom));
            top = ($urandom_range(0, 5) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
            cmd = {top, 3'($urandom_range(0, 7)), 11'($urandom)};
            case ($urandom_range(0, 5))
                0:       nr = 12;
                1:       nr = 15;
                2:       nr = 17;
                default: nr = 16;
            endcase
            run("rand", cmd, nr, 1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)),
                12'($urandom), 1'b0, 3'd0, 12'h000);
        end

        // reset in the middle of a frame
        wr(3'd1, 12'hBEE);
        v0 = n_vld; e0 = n_err;
        @(negedge clk);
        SS_n = 1'b0;
        wait_clk(HP);
        for (int i = 0; i < 8; i++) begin
            SCLK = 1'b0; MOSI = 1'b1; wait_clk(HP);
            SCLK = 1'b1; wait_clk(HP);
        end
        rst = 1'b1;
        wait_clk(3);
        SS_n = 1'b1;
        wait_clk(2);
        rst = 1'b0;
        mreset();
        wait_clk(6);
        chk("midrst vld", 32'(n_vld - v0), 32'd0);
        chk("midrst err", 32'(n_err - e0), 32'd0);
        chk("midrst chnl", 32'(cmd_chnl), 32'd0);
        plain("post_rst", 16'h0800, 16);
        plain("post_rst2", 16'h0000, 16);

        // SS_n held low through reset release
        rst = 1'b1;
        SS_n = 1'b0;
        wait_clk(3);
        rst = 1'b0;
        mreset();
        v0 = n_vld; e0 = n_err;
        wait_clk(8);
        for (int i = 0; i < 16; i++) begin
            SCLK = 1'b0; MOSI = 1'b0; wait_clk(HP);
            if (i == 8) chk("hold MISO", 32'(MISO), 32'd0);
            SCLK = 1'b1; wait_clk(HP);
        end
        SS_n = 1'b1;
        wait_clk(8);
        chk("hold vld", 32'(n_vld - v0), 32'd0);
        chk("hold err", 32'(n_err - e0), 32'd0);
        plain("after_hold", 16'h3000, 16);
        plain("after_hold2", 16'h0000, 16);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule
